// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: geometry, widths, FSM states and pixel helpers for the LED framebuffer
package led_matrix_pkg;
  localparam int COLS       = 64;
  localparam int ROWS_HALF  = 16;
  localparam int COLOR_BITS = 6;
  localparam int COL_W      = 8;
  localparam int ROW_W      = 4;
  localparam int Y_W        = 5;
  localparam int PIX_W      = 3 * COLOR_BITS;
  localparam int DEPTH      = COLS * ROWS_HALF;
  localparam int ADDR_W     = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  // Pixel word is {B,G,R}; each output bit is set when its channel has the selected bit-plane set
  function automatic logic [2:0] pix_bits(input logic [PIX_W-1:0] p, input logic [COLOR_BITS-1:0] m);
    return {|(p[3*COLOR_BITS-1:2*COLOR_BITS] & m), |(p[2*COLOR_BITS-1:COLOR_BITS] & m), |(p[COLOR_BITS-1:0] & m)};
  endfunction
endpackage

// File: rtl/pixel_ram.sv
// pixel_ram: simple dual-port pixel store with one write port and a registered read port
module pixel_ram
  import led_matrix_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);
  logic [PIX_W-1:0] mem_q [DEPTH];
  // Write when enabled; read is always registered so reads never stall
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/matrix_framebuffer.sv
// matrix_framebuffer: double-buffered LED panel pixel store with tear-free frame-boundary swap
module matrix_framebuffer
  import led_matrix_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [COL_W-1:0]      column_address,
  input  logic [ROW_W-1:0]      row_address,
  input  logic [COLOR_BITS-1:0] brightness_mask,
  input  logic                  frame_start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [COL_W-1:0]      wr_x,
  input  logic [Y_W-1:0]        wr_y,
  input  logic [COLOR_BITS-1:0] wr_red,
  input  logic [COLOR_BITS-1:0] wr_green,
  input  logic [COLOR_BITS-1:0] wr_blue,
  output logic                  wr_dropped,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic [2:0]            rgb1,
  output logic [2:0]            rgb2
);
  state_t                state_q;
  logic [ADDR_W-1:0]     clr_cnt_q;
  logic                  front_sel_q, swap_pending_q, wr_dropped_q, rd_en_q, rd_sel_q;
  logic [COLOR_BITS-1:0] mask_q;
  logic [PIX_W-1:0]      rdata [4];
  logic [3:0]            we;
  logic [ADDR_W-1:0]     waddr, raddr;
  logic [PIX_W-1:0]      wdata, top, bot;
  logic                  acc, in_range, clearing;
  // Handshake, address muxing and masked read-out from the front bank
  always_comb begin
    clearing     = state_q == ST_CLEAR;
    wr_ready     = !clearing && !swap_pending_q;
    acc          = wr_valid && wr_ready;
    in_range     = wr_x < COL_W'(COLS);
    waddr        = clearing ? clr_cnt_q : {wr_y[ROW_W-1:0], wr_x[ADDR_W-ROW_W-1:0]};
    wdata        = clearing ? '0 : {wr_blue, wr_green, wr_red};
    raddr        = {row_address, column_address[ADDR_W-ROW_W-1:0]};
    top          = rd_sel_q ? rdata[2] : rdata[0];
    bot          = rd_sel_q ? rdata[3] : rdata[1];
    rgb1         = rd_en_q ? pix_bits(top, mask_q) : 3'b000;
    rgb2         = rd_en_q ? pix_bits(bot, mask_q) : 3'b000;
    wr_dropped   = wr_dropped_q;
    swap_pending = swap_pending_q;
  end
  // RAM index i: bank = i/2, half = i%2; clearing zeroes all four, writes only hit the back bank
  for (genvar i = 0; i < 4; i++) begin : g_ram
    assign we[i] = clearing || (acc && in_range && (front_sel_q != 1'(i / 2)) && (wr_y[Y_W-1] == 1'(i % 2)));
    pixel_ram u_ram (
      .clk_i  (clk_in),
      .we_i   (we[i]),
      .waddr_i(waddr),
      .wdata_i(wdata),
      .raddr_i(raddr),
      .rdata_o(rdata[i])
    );
  end
  // Clear/run FSM, swap arbitration and read-side pipeline registers
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q        <= ST_CLEAR;
      clr_cnt_q      <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_dropped_q   <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_sel_q       <= 1'b0;
      mask_q         <= '0;
    end else begin
      wr_dropped_q <= acc && !in_range;
      rd_en_q      <= !clearing && column_address < COL_W'(COLS);
      rd_sel_q     <= front_sel_q;
      mask_q       <= brightness_mask;
      if (clearing) begin
        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_q <= ST_RUN;
      end else if (frame_start && (swap_pending_q || swap_req)) begin
        front_sel_q    <= !front_sel_q;
        swap_pending_q <= 1'b0;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_matrix_framebuffer.sv
// tb_matrix_framebuffer: randomized self-checking bench against a frame-array reference model
module tb_matrix_framebuffer;
  logic       clk_in = 1'b0, reset = 1'b0;
  logic [7:0] column_address = '0;
  logic [3:0] row_address = '0;
  logic [5:0] brightness_mask = '0;
  logic       frame_start = 1'b0, wr_valid = 1'b0, swap_req = 1'b0;
  logic [7:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [5:0] wr_red = '0, wr_green = '0, wr_blue = '0;
  logic       wr_ready, wr_dropped, swap_pending;
  logic [2:0] rgb1, rgb2;

  typedef struct packed {logic [5:0] r, g, b;} px_t;
  px_t mem [2][32][64];
  int  front;
  int  n_assert = 0, n_fail = 0;

  matrix_framebuffer dut (
    .clk_in(clk_in), .reset(reset), .column_address(column_address), .row_address(row_address),
    .brightness_mask(brightness_mask), .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
    .wr_dropped(wr_dropped), .swap_req(swap_req), .swap_pending(swap_pending), .rgb1(rgb1), .rgb2(rgb2)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [2:0] expect_bits(input px_t p, input logic [5:0] m);
    logic [2:0] e;
    e[0] = (p.r & m) != 0;
    e[1] = (p.g & m) != 0;
    e[2] = (p.b & m) != 0;
    return e;
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 64; x++) mem[b][y][x] = '0;
    front = 0;
  endtask

  function automatic int pick_x(input int k);
    return k < 8 ? k : k + 55;
  endfunction

  task automatic check_read(input int col, input int row, input logic [5:0] m);
    logic [2:0] e1, e2;
    column_address  = col[7:0];
    row_address     = row[3:0];
    brightness_mask = m;
    step();
    e1 = 3'b000;
    e2 = 3'b000;
    if (col < 64) begin
      e1 = expect_bits(mem[front][row][col], m);
      e2 = expect_bits(mem[front][row + 16][col], m);
    end
    n_assert += 2;
    if (rgb1 !== e1) begin
      n_fail++;
      $display("FAIL read_rgb1 col=%0d row=%0d mask=%h: got %b, expected %b", col, row, m, rgb1, e1);
    end
    if (rgb2 !== e2) begin
      n_fail++;
      $display("FAIL read_rgb2 col=%0d row=%0d mask=%h: got %b, expected %b", col, row, m, rgb2, e2);
    end
  endtask

  task automatic check_region();
    for (int y = 0; y < 16; y++)
      for (int k = 0; k < 13; k++) check_read(pick_x(k), y, 6'(32'd1 << $urandom_range(0, 5)));
  endtask

  task automatic write_px(input int x, input int y, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    wr_x = x[7:0]; wr_y = y[4:0]; wr_red = r; wr_green = g; wr_blue = b; wr_valid = 1'b1;
    n_assert++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ready_before_write: got %b, expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    if (x < 64) mem[1 - front][y][x] = '{r: r, g: g, b: b};
    n_assert++;
    if (wr_dropped !== (x >= 64)) begin
      n_fail++;
      $display("FAIL wr_dropped x=%0d: got %b, expected %b", x, wr_dropped, x >= 64);
    end
    step();
    n_assert++;
    if (wr_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_dropped_pulse_width: got %b, expected 0", wr_dropped);
    end
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_assert++;
    if (swap_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_pending_set: got %b, expected 1", swap_pending);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    front = 1 - front;
    n_assert += 2;
    if (swap_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_pending_clear: got %b, expected 0", swap_pending);
    end
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ready_after_swap: got %b, expected 1", wr_ready);
    end
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      column_address  = 8'($urandom);
      row_address     = 4'($urandom);
      brightness_mask = 6'(32'd1 << $urandom_range(0, 5));
      step();
      n++;
      n_assert++;
      if (rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_rgb_during_clear cycle=%0d: got %b/%b, expected 000/000", tag, n, rgb1, rgb2);
      end
    end
    n_assert++;
    if (n !== 1024) begin
      n_fail++;
      $display("FAIL %s_clear_cycles: got %0d, expected 1024", tag, n);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_assert++;
    if ({rgb1, rgb2, wr_ready, wr_dropped, swap_pending} !== 9'b0) begin
      n_fail++;
      $display("FAIL %s_reset_outputs: got rgb1=%b rgb2=%b rdy=%b drop=%b pend=%b, expected all 0",
               tag, rgb1, rgb2, wr_ready, wr_dropped, swap_pending);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    check_idle_outputs("por");
    reset = 1'b1;
    wait_clear("por");
    clear_model();
    check_read(5, 3, 6'h20);
  endtask

  task automatic test_directed();
    write_px(5, 3, 6'h3F, 6'h00, 6'h20);
    do_swap();
    check_read(5, 3, 6'h20);
    n_assert++;
    if (rgb1 !== 3'b101 || rgb2 !== 3'b000) begin
      n_fail++;
      $display("FAIL directed_mask20: got %b/%b, expected 101/000", rgb1, rgb2);
    end
    check_read(5, 3, 6'h01);
    n_assert++;
    if (rgb1 !== 3'b001) begin
      n_fail++;
      $display("FAIL directed_mask01: got %b, expected 001", rgb1);
    end
    write_px(5, 19, 6'h00, 6'h01, 6'h00);
    do_swap();
    check_read(5, 3, 6'h01);
    n_assert++;
    if (rgb2 !== 3'b010) begin
      n_fail++;
      $display("FAIL directed_bottom: got %b, expected 010", rgb2);
    end
    check_read(64, 3, 6'h01);
    check_read(255, 3, 6'h01);
  endtask

  task automatic test_dropped();
    write_px(64, 3, 6'h3F, 6'h3F, 6'h3F);
    write_px(200, 19, 6'h3F, 6'h3F, 6'h3F);
    write_px(63, 31, 6'h15, 6'h2A, 6'h3F);
    do_swap();
    check_region();
    check_read(63, 15, 6'h01);
    check_read(63, 15, 6'h02);
  endtask

  task automatic test_pending();
    write_px(1, 1, 6'h3F, 6'h00, 6'h00);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1; wr_x = 8'd1; wr_y = 5'd1; wr_red = 6'h00; wr_green = 6'h3F; wr_blue = 6'h3F;
      swap_req = (i == 50);
      step();
      n_assert++;
      if (swap_pending !== 1'b1 || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL pending_hold cycle=%0d: got pend=%b rdy=%b, expected pend=1 rdy=0", i, swap_pending, wr_ready);
      end
    end
    wr_valid = 1'b0;
    swap_req = 1'b0;
    check_read(1, 1, 6'h01);
    check_read(5, 3, 6'h20);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    front = 1 - front;
    n_assert++;
    if (swap_pending !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_release: got pend=%b rdy=%b, expected pend=0 rdy=1", swap_pending, wr_ready);
    end
    check_read(1, 1, 6'h01);
    check_read(1, 1, 6'h10);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_read(1, 1, 6'h01);
  endtask

  task automatic test_immediate();
    wr_valid = 1'b1; wr_x = 8'd2; wr_y = 5'd18; wr_red = 6'h01; wr_green = 6'h02; wr_blue = 6'h04;
    swap_req = 1'b1; frame_start = 1'b1;
    n_assert++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL immediate_ready: got %b, expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    mem[1 - front][18][2] = '{r: 6'h01, g: 6'h02, b: 6'h04};
    front = 1 - front;
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (swap_pending !== 1'b0) begin
        n_fail++;
        $display("FAIL immediate_no_pending cycle=%0d: got %b, expected 0", i, swap_pending);
      end
      check_read(2, 2, 6'(32'd1 << i));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int op = $urandom_range(0, 9);
      if (op < 5) write_px(pick_x($urandom_range(0, 12)), $urandom_range(0, 31), 6'($urandom), 6'($urandom), 6'($urandom));
      else if (op < 7) do_swap();
      else check_read(pick_x($urandom_range(0, 12)), $urandom_range(0, 15), 6'($urandom));
    end
    check_region();
    do_swap();
    check_region();
  endtask

  task automatic test_reset_mid_run();
    write_px(3, 4, 6'h3F, 6'h3F, 6'h3F);
    do_swap();
    write_px(3, 20, 6'h3F, 6'h3F, 6'h3F);
    reset = 1'b0;
    step();
    check_idle_outputs("mid_run");
    reset = 1'b1;
    repeat (300) step();
    reset = 1'b0;
    step();
    check_idle_outputs("mid_clear");
    reset = 1'b1;
    wait_clear("restart");
    clear_model();
    check_region();
    do_swap();
    check_region();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_directed();
    test_dropped();
    test_pending();
    test_immediate();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
